// File: rtl/key_event_filter.sv
// key_event_filter
//   Conditions raw DE2 inputs for the control core. Push-buttons (active-low,
//   bouncy) become clean one-cycle press/release/long-press pulses plus a
//   debounced level. Slide switches become a debounced vector with a change
//   strobe.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_key          raw push-buttons, 0 = pressed
//   i_sw           raw slide switches
//   o_key_press    one-cycle pulse per key on an accepted press
//   o_key_release  one-cycle pulse per key on an accepted release
//   o_key_long     one-cycle pulse once per press when the hold time is reached
//   o_key_level    debounced pressed level, 1 = pressed
//   o_sw           debounced, synchronised switch vector
//   o_sw_change    one-cycle pulse in the cycle o_sw takes a new value
//
// The per-key FSM state is held in key_state[] so checkers can bind to it.
module key_event_filter #(
    parameter int NUM_KEYS          = 4,
    parameter int SW_WIDTH          = 18,
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key,
    input  logic [SW_WIDTH-1:0] i_sw,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_long,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [SW_WIDTH-1:0] o_sw,
    output logic                o_sw_change
);

    localparam int CW  = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int SCW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0]  DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  HOLD_PRE   = CW'(LONG_PRESS_CYCLES - 2);
    localparam logic [CW-1:0]  HOLD_MAX   = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [SCW-1:0] SW_LAST    = SCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCW-1:0] SW_ONE     = SCW'(1);

    typedef enum logic [2:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        LONG_HELD,
        RELEASE_PEND
    } key_state_t;

    // Two-flop synchronisers
    logic [NUM_KEYS-1:0] key_s1, key_s2;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2, sw_prev;
    logic [SCW-1:0]      sw_cnt;

    // Per-key state
    key_state_t          key_state [NUM_KEYS];
    key_state_t          state_d   [NUM_KEYS];
    logic [CW-1:0]       deb_q     [NUM_KEYS];
    logic [CW-1:0]       deb_d     [NUM_KEYS];
    logic [CW-1:0]       hold_q    [NUM_KEYS];
    logic [CW-1:0]       hold_d    [NUM_KEYS];
    // Remembers whether RELEASE_PEND was entered from LONG_HELD
    logic [NUM_KEYS-1:0] origin_long_q, origin_long_d;
    logic [NUM_KEYS-1:0] press_d, release_d, long_d, level_d;

    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i]       = key_state[i];
            deb_d[i]         = deb_q[i];
            hold_d[i]        = hold_q[i];
            origin_long_d[i] = origin_long_q[i];
            press_d[i]       = 1'b0;
            release_d[i]     = 1'b0;
            long_d[i]        = 1'b0;
            level_d[i]       = o_key_level[i];

            case (key_state[i])
                RELEASED: begin
                    if (!key_s2[i]) begin
                        state_d[i] = PRESS_PEND;
                        deb_d[i]   = CNT_ONE;
                    end
                end
                PRESS_PEND: begin
                    if (key_s2[i]) begin
                        state_d[i] = RELEASED;
                        deb_d[i]   = '0;
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i] = PRESSED;
                        deb_d[i]   = '0;
                        hold_d[i]  = '0;
                        press_d[i] = 1'b1;
                        level_d[i] = 1'b1;
                    end else begin
                        deb_d[i] = deb_q[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (key_s2[i]) begin
                        state_d[i]       = RELEASE_PEND;
                        deb_d[i]         = CNT_ONE;
                        origin_long_d[i] = 1'b0;
                    end else if (hold_q[i] == HOLD_PRE) begin
                        state_d[i] = LONG_HELD;
                        hold_d[i]  = HOLD_MAX;
                        long_d[i]  = 1'b1;
                    end else begin
                        hold_d[i] = hold_q[i] + CNT_ONE;
                    end
                end
                LONG_HELD: begin
                    if (key_s2[i]) begin
                        state_d[i]       = RELEASE_PEND;
                        deb_d[i]         = CNT_ONE;
                        origin_long_d[i] = 1'b1;
                    end
                end
                RELEASE_PEND: begin
                    if (!key_s2[i]) begin
                        // Glitch rejected: the return cycle counts as a held
                        // cycle, so a glitch of N cycles delays the long press
                        // by exactly N cycles.
                        deb_d[i] = '0;
                        if (origin_long_q[i]) begin
                            state_d[i] = LONG_HELD;
                        end else if (hold_q[i] == HOLD_PRE) begin
                            state_d[i] = LONG_HELD;
                            hold_d[i]  = HOLD_MAX;
                            long_d[i]  = 1'b1;
                        end else begin
                            state_d[i] = PRESSED;
                            hold_d[i]  = hold_q[i] + CNT_ONE;
                        end
                    end else if (deb_q[i] == DEB_LAST) begin
                        state_d[i]   = RELEASED;
                        deb_d[i]     = '0;
                        hold_d[i]    = '0;
                        release_d[i] = 1'b1;
                        level_d[i]   = 1'b0;
                    end else begin
                        deb_d[i] = deb_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = RELEASED;
                    deb_d[i]   = '0;
                    hold_d[i]  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            key_s1        <= '1;
            key_s2        <= '1;
            o_key_press   <= '0;
            o_key_release <= '0;
            o_key_long    <= '0;
            o_key_level   <= '0;
            origin_long_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_state[i] <= RELEASED;
                deb_q[i]     <= '0;
                hold_q[i]    <= '0;
            end
        end else begin
            key_s1        <= i_key;
            key_s2        <= key_s1;
            o_key_press   <= press_d;
            o_key_release <= release_d;
            o_key_long    <= long_d;
            o_key_level   <= level_d;
            origin_long_q <= origin_long_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_state[i] <= state_d[i];
                deb_q[i]     <= deb_d[i];
                hold_q[i]    <= hold_d[i];
            end
        end
    end

    // Switches share one stability counter. The cycle a change is seen counts
    // as the first stable cycle, matching key latency. The counter parks at
    // its last value so a stable vector is reloaded every cycle; the strobe
    // fires only when the loaded value actually differs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_s1       <= '0;
            sw_s2       <= '0;
            sw_prev     <= '0;
            sw_cnt      <= '0;
            o_sw        <= '0;
            o_sw_change <= 1'b0;
        end else begin
            sw_s1       <= i_sw;
            sw_s2       <= sw_s1;
            sw_prev     <= sw_s2;
            o_sw_change <= 1'b0;
            if (sw_s2 != sw_prev) begin
                sw_cnt <= SW_ONE;
            end else if (sw_cnt == SW_LAST) begin
                o_sw        <= sw_s2;
                o_sw_change <= (sw_s2 != o_sw);
            end else begin
                sw_cnt <= sw_cnt + SW_ONE;
            end
        end
    end

endmodule

// File: tb/tb_key_event_filter.sv
module tb_key_event_filter;

  localparam int NK = 4;
  localparam int SW = 18;
  localparam int D  = 8;
  localparam int L  = 32;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [NK-1:0] key;
  logic [SW-1:0] sw;
  logic [NK-1:0] o_key_press, o_key_release, o_key_long, o_key_level;
  logic [SW-1:0] o_sw;
  logic          o_sw_change;

  key_event_filter #(
    .NUM_KEYS(NK), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_key(key), .i_sw(sw),
    .o_key_press(o_key_press), .o_key_release(o_key_release),
    .o_key_long(o_key_long), .o_key_level(o_key_level),
    .o_sw(o_sw), .o_sw_change(o_sw_change)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: behavioural, counts runs of stable samples
  logic [NK-1:0] m_k1, m_k2, m_lvl, m_press, m_rel, m_long;
  int            m_run [NK];
  int            m_hold [NK];
  logic [SW-1:0] m_sw1, m_sw2, m_swprev, m_osw;
  int            m_swrun;
  logic          m_swchg;

  // event recorders (observed on DUT outputs)
  int press_cnt [NK];
  int rel_cnt [NK];
  int long_cnt [NK];
  int last_press [NK];
  int last_rel [NK];
  int last_long [NK];
  int sw_chg_cnt = 0;
  int last_sw_chg = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [NK-1:0] ks;
    logic [SW-1:0] ss;
    logic p;
    if (rst) begin
      m_k1 = '1; m_k2 = '1; m_lvl = '0;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NK; i++) begin
        m_run[i] = 0;
        m_hold[i] = 0;
      end
      m_sw1 = '0; m_sw2 = '0; m_swprev = '0; m_osw = '0;
      m_swrun = 0; m_swchg = 1'b0;
      return;
    end
    ks = m_k2; m_k2 = m_k1; m_k1 = key;
    m_press = '0; m_rel = '0; m_long = '0;
    for (int i = 0; i < NK; i++) begin
      p = ~ks[i];
      if (p != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = p;
          m_run[i] = 0;
          if (p) begin
            m_press[i] = 1'b1;
            m_hold[i] = 0;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
        if (m_lvl[i] && m_hold[i] < L - 1) begin
          m_hold[i]++;
          if (m_hold[i] == L - 1) m_long[i] = 1'b1;
        end
      end
    end
    ss = m_sw2; m_sw2 = m_sw1; m_sw1 = sw;
    m_swchg = 1'b0;
    if (ss != m_swprev) m_swrun = 1;
    else if (m_swrun < D) m_swrun++;
    m_swprev = ss;
    if (m_swrun >= D) begin
      if (ss != m_osw) m_swchg = 1'b1;
      m_osw = ss;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("key_press", 32'(o_key_press), 32'(m_press));
    check("key_release", 32'(o_key_release), 32'(m_rel));
    check("key_long", 32'(o_key_long), 32'(m_long));
    check("key_level", 32'(o_key_level), 32'(m_lvl));
    check("sw", 32'(o_sw), 32'(m_osw));
    check("sw_change", 32'(o_sw_change), 32'(m_swchg));
    for (int i = 0; i < NK; i++) begin
      if (o_key_press[i] === 1'b1) begin press_cnt[i]++; last_press[i] = cyc; end
      if (o_key_release[i] === 1'b1) begin rel_cnt[i]++; last_rel[i] = cyc; end
      if (o_key_long[i] === 1'b1) begin long_cnt[i]++; last_long[i] = cyc; end
    end
    if (o_sw_change === 1'b1) begin sw_chg_cnt++; last_sw_chg = cyc; end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int e0, e1, r, chg0;
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
    end
    rst = 1'b1;
    key = '1;
    sw  = '0;
    ticks(2);
    check("reset_level", 32'(o_key_level), 32'h0);
    check("reset_sw", 32'(o_sw), 32'h0);
    rst = 1'b0;
    ticks(12);

    // 1: clean press and release on key 0
    key[0] = 1'b0;
    e0 = cyc + 1;
    ticks(20);
    check("t1_press_cnt", 32'(press_cnt[0]), 32'd1);
    check("t1_press_cycle", 32'(last_press[0]), 32'(e0 + 1 + D));
    check("t1_level", 32'(o_key_level[0]), 32'd1);
    key[0] = 1'b1;
    e1 = cyc + 1;
    ticks(15);
    check("t1_release_cnt", 32'(rel_cnt[0]), 32'd1);
    check("t1_release_cycle", 32'(last_rel[0]), 32'(e1 + 1 + D));
    check("t1_no_long", 32'(long_cnt[0]), 32'd0);

    // 2: bounce rejection on key 1
    key[1] = 1'b0; ticks(5);
    key[1] = 1'b1; ticks(2);
    key[1] = 1'b0; ticks(5);
    key[1] = 1'b1; ticks(15);
    check("t2_press_cnt", 32'(press_cnt[1]), 32'd0);
    check("t2_release_cnt", 32'(rel_cnt[1]), 32'd0);
    check("t2_long_cnt", 32'(long_cnt[1]), 32'd0);
    check("t2_level", 32'(o_key_level[1]), 32'd0);

    // 3: long press on key 2
    key[2] = 1'b0; ticks(60);
    key[2] = 1'b1; ticks(15);
    check("t3_press_cnt", 32'(press_cnt[2]), 32'd1);
    check("t3_long_cnt", 32'(long_cnt[2]), 32'd1);
    check("t3_long_delay", 32'(last_long[2] - last_press[2]), 32'(L - 1));
    check("t3_release_cnt", 32'(rel_cnt[2]), 32'd1);

    // 4: 3-cycle release glitch on key 3 while pressed
    key[3] = 1'b0; ticks(15);
    key[3] = 1'b1; ticks(3);
    key[3] = 1'b0; ticks(50);
    check("t4_release_during", 32'(rel_cnt[3]), 32'd0);
    check("t4_level", 32'(o_key_level[3]), 32'd1);
    check("t4_long_delay", 32'(last_long[3] - last_press[3]), 32'(L - 1 + 3));
    key[3] = 1'b1; ticks(15);
    check("t4_release_cnt", 32'(rel_cnt[3]), 32'd1);
    check("t4_long_cnt", 32'(long_cnt[3]), 32'd1);

    // 5: switches with a bouncing bit 0
    chg0 = sw_chg_cnt;
    sw = 18'h00005; ticks(4);
    e0 = 0;
    for (int t = 0; t < 5; t++) begin
      sw[0] = ~sw[0];
      e0 = cyc + 1;
      ticks(4);
    end
    ticks(15);
    check("t5_sw_value", 32'(o_sw), 32'h4);
    check("t5_sw_change_cnt", 32'(sw_chg_cnt - chg0), 32'd1);
    check("t5_sw_change_cycle", 32'(last_sw_chg), 32'(e0 + 1 + D));

    // 6: reset during PRESS_PEND with keys 0 and 1 held
    key[1:0] = 2'b00;
    ticks(4);
    rst = 1'b1;
    tick();
    r = cyc;
    check("t6_rst_press", 32'(o_key_press), 32'h0);
    check("t6_rst_level", 32'(o_key_level), 32'h0);
    check("t6_rst_sw", 32'(o_sw), 32'h0);
    check("t6_rst_sw_change", 32'(o_sw_change), 32'h0);
    rst = 1'b0;
    ticks(20);
    check("t6_press0_cycle", 32'(last_press[0]), 32'(r + 2 + D));
    check("t6_press1_cycle", 32'(last_press[1]), 32'(r + 2 + D));
    check("t6_level", 32'(o_key_level[1:0]), 32'h3);
    key[1:0] = 2'b11;
    ticks(15);

    // random phase: bouncy keys, switch flips, occasional reset
    for (int t = 0; t < 500; t++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 11) == 0) key[i] = ~key[i];
      if ($urandom_range(0, 15) == 0) sw[$urandom_range(0, SW - 1)] ^= 1'b1;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    key = '1;
    ticks(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
